mul_issue: RTL and testbench

- Execute-stage controller between the decoded-instruction datapath and the iterative 64-bit multiplier core.
- Accepts MUL/MULW requests and stalls the pipeline while the multiplier iterates.
- Drives the core's valid/a/b/resetn, waits for its done handshake, and registers the low-64 product.
- Applies RV64 W-form sign extension and returns a one-cycle result pulse to execute.

---
 rtl/mul_issue.sv | 161 ++++++++++++++++
 tb/tb_mul_issue.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_issue.sv
// mul_issue: execute-stage controller for an iterative multiplier core.
//
// Takes MUL/MULW requests from execute and holds the pipeline (stall) while the
// core works. It drives the core's valid/a/b/resetn, waits for the done
// handshake and registers the low WORD_BITS of the product. For MULW it
// sign-extends the low half-word. The result goes back to execute as a
// one-cycle resp_valid pulse.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req_valid, req_word  request strobe (held until resp_valid), 0=MUL 1=MULW
//   src1, src2           operands
//   flush                kills the in-flight op; no response is produced for it
//   stall                execute must hold
//   resp_valid           one-cycle result strobe
//   resp_data            result, held until the next capture
//   mul_valid, mul_resetn, mul_a, mul_b   to the multiplier core
//   mul_done, mul_c                       from the multiplier core
//
// Build option:
//   MUL_FASTPATH_EN  when defined, an op whose prepared operand a or b is zero
//                    skips the core and returns 0 two cycles after accept.
module mul_issue #(
  parameter int WORD_BITS = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_word,
  input  logic [WORD_BITS-1:0] src1,
  input  logic [WORD_BITS-1:0] src2,
  input  logic                 flush,
  output logic                 stall,
  output logic                 resp_valid,
  output logic [WORD_BITS-1:0] resp_data,
  output logic                 mul_valid,
  output logic                 mul_resetn,
  output logic [WORD_BITS-1:0] mul_a,
  output logic [WORD_BITS-1:0] mul_b,
  input  logic                 mul_done,
  input  logic [WORD_BITS-1:0] mul_c
);

  localparam int HALF = WORD_BITS / 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3
`ifdef MUL_FASTPATH_EN
    , S_FAST  = 3'd4
`endif
  } state_t;

  function automatic logic signed [WORD_BITS-1:0] sext_half(input logic [WORD_BITS-1:0] x);
    logic signed [HALF-1:0] lo;
    lo = x[HALF-1:0];
    return WORD_BITS'(lo);
  endfunction

  function automatic logic [WORD_BITS-1:0] prep_operand(input logic               word,
                                                        input logic [WORD_BITS-1:0] x);
    return word ? sext_half(x) : x;
  endfunction

  state_t                 state_q, state_d;
  logic [WORD_BITS-1:0]   op_a_q, op_a_d;
  logic [WORD_BITS-1:0]   op_b_q, op_b_d;
  logic                   word_q, word_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [WORD_BITS-1:0]   resp_data_q, resp_data_d;
  logic [WORD_BITS-1:0]   a_prep, b_prep;

  assign mul_resetn = ~(reset | flush);
  assign stall      = req_valid & ~resp_valid_q;
  // The core's sign fix-up reads a/b combinationally, so they come straight
  // from the operand registers and stay put until the op is captured.
  assign mul_a      = op_a_q;
  assign mul_b      = op_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    word_d       = word_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    mul_valid    = 1'b0;
    a_prep       = prep_operand(req_word, src1);
    b_prep       = prep_operand(req_word, src2);

    case (state_q)
      S_IDLE: begin
        // While resp_valid is high execute still presents the finished op.
        if (req_valid && !resp_valid_q && !flush) begin
          op_a_d  = a_prep;
          op_b_d  = b_prep;
          word_d  = req_word;
          state_d = S_LAUNCH;
`ifdef MUL_FASTPATH_EN
          if (a_prep == '0 || b_prep == '0) begin
            state_d = S_FAST;
          end
`endif
        end
      end
      S_LAUNCH: begin
        mul_valid = ~reset;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // done is also high while the core idles, so it is only trusted here.
        if (mul_done) begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        resp_data_d  = word_q ? sext_half(mul_c) : mul_c;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
`ifdef MUL_FASTPATH_EN
      S_FAST: begin
        resp_data_d  = '0;
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d      = S_IDLE;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
    end
  end

  // ---- state / operand / result registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      word_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      word_q       <= word_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
module tb_mul_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        mul_valid;
  logic        mul_resetn;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic        mul_done = 1'b1;
  logic [63:0] mul_c = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  mul_issue #(.WORD_BITS(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_word(req_word),
    .src1(src1), .src2(src2), .flush(flush), .stall(stall),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mul_valid(mul_valid), .mul_resetn(mul_resetn), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_c(mul_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural iterative core: done drops after valid, rises core_lat+1 cycles later.
  int core_lat = 3;
  int core_cnt = 0;
  bit core_busy = 1'b0;
  always @(posedge clk) begin
    if (!mul_resetn) begin
      core_busy <= 1'b0;
      mul_done  <= 1'b1;
      core_cnt  <= 0;
    end else if (mul_valid) begin
      core_busy <= 1'b1;
      mul_done  <= 1'b0;
      core_cnt  <= core_lat;
    end else if (core_busy) begin
      if (core_cnt <= 1) begin
        core_busy <= 1'b0;
        mul_done  <= 1'b1;
        mul_c     <= mul_a * mul_b;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Event monitor.
  int          n_mv = 0;
  int          n_rv = 0;
  int          v_cyc = 0;
  int          d_cyc = 0;
  bit          done_prev = 1'b1;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;
  always @(negedge clk) begin
    if (mul_valid) begin
      n_mv   <= n_mv + 1;
      v_cyc  <= cycle;
      last_a <= mul_a;
      last_b <= mul_b;
    end
    if (resp_valid) n_rv <= n_rv + 1;
    if (mul_done && !done_prev) d_cyc <= cycle;
    done_prev <= mul_done;
  end

  int exp_mv = 0;
  int exp_rv = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] sext32(input logic [63:0] x);
    int lo;
    lo = int'(x[31:0]);
    return 64'(longint'(lo));
  endfunction

  function automatic logic [63:0] prep(input bit w, input logic [63:0] x);
    return w ? sext32(x) : x;
  endfunction

  function automatic logic [63:0] ref_mul(input bit w, input logic [63:0] a, input logic [63:0] b);
    longint p;
    if (!w) return a * b;
    p = longint'(int'(a[31:0])) * longint'(int'(b[31:0]));
    return sext32(64'(p));
  endfunction

  // Present one op at an IDLE cycle, wait for its response and check it.
  task automatic run_op(input bit w, input logic [63:0] a, input logic [63:0] b,
                        input int lat, input bit hold);
    logic [63:0] exp;
    int          cyc;
    bit          fast;
    exp  = ref_mul(w, a, b);
    fast = 1'b0;
`ifdef MUL_FASTPATH_EN
    fast = (prep(w, a) == 64'd0) || (prep(w, b) == 64'd0);
`endif
    core_lat  = lat;
    req_valid = 1'b1;
    req_word  = w;
    src1      = a;
    src2      = b;
    #1;
    check_eq("stall_busy", 64'(stall), 64'd1);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!resp_valid && cyc < 200);
    check_eq("resp_seen", 64'(resp_valid), 64'd1);
    exp_rv++;
    if (!fast) exp_mv++;
    check_eq("resp_data", resp_data, exp);
    check_eq("stall_in_resp", 64'(stall), 64'd0);
    check_eq("mul_valid_pulses", 64'(n_mv), 64'(exp_mv));
    check_eq("resp_pulses", 64'(n_rv), 64'(exp_rv));
    if (fast) begin
      check_eq("latency_fast", 64'(cyc), 64'd2);
    end else begin
      check_eq("latency", 64'(cyc), 64'(3 + d_cyc - v_cyc));
      check_eq("mul_a", last_a, prep(w, a));
      check_eq("mul_b", last_b, prep(w, b));
    end
    if (!hold) req_valid = 1'b0;
    step();
    check_eq("resp_one_cycle", 64'(resp_valid), 64'd0);
    check_eq("resp_data_hold", resp_data, exp);
    check_eq("no_double_accept", 64'(n_mv), 64'(exp_mv));
  endtask

  initial begin
    logic [63:0] prev;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_word  = 1'b0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    repeat (3) step();
    check_eq("rst_mul_resetn", 64'(mul_resetn), 64'd0);
    check_eq("rst_mul_valid", 64'(mul_valid), 64'd0);
    reset = 1'b0;
    step();
    check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("rst_resp_data", resp_data, 64'd0);
    check_eq("rst_mul_a", mul_a, 64'd0);
    check_eq("rst_mul_b", mul_b, 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    check_eq("rst_release_resetn", 64'(mul_resetn), 64'd1);

    // Directed ops.
    run_op(1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 3, 1'b0);
    check_eq("mul_7x-3", resp_data, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1'b1, 64'h0000_0001_8000_0000, 64'd2, 4, 1'b0);
    check_eq("mulw_a_sext", last_a, 64'hFFFF_FFFF_8000_0000);
    check_eq("mulw_zero_lo", resp_data, 64'd0);
    run_op(1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 2, 1'b0);
    check_eq("mulw_wrap", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    check_eq("mul_overflow", resp_data, 64'd1);

    // Flush in the 10th WAIT cycle.
    core_lat  = 40;
    req_valid = 1'b1;
    req_word  = 1'b0;
    src1      = 64'd9;
    src2      = 64'd9;
    repeat (11) step();
    flush     = 1'b1;
    req_valid = 1'b0;
    #1;
    check_eq("flush_resetn", 64'(mul_resetn), 64'd0);
    exp_mv++;
    step();
    flush = 1'b0;
    check_eq("flush_no_resp", 64'(resp_valid), 64'd0);
    check_eq("flush_launched_once", 64'(n_mv), 64'(exp_mv));
    run_op(1'b0, 64'd3, 64'd5, 3, 1'b0);
    check_eq("after_flush_3x5", resp_data, 64'd15);

    // Back-to-back with req_valid held through the response cycle.
    run_op(1'b0, 64'd1000, 64'hFFFF_FFFF_FFFF_FFF0, 2, 1'b1);
    run_op(1'b1, 64'h1234_5678_0000_1111, 64'hABCD_0000_FFFF_0003, 5, 1'b0);

    // Flush in the CAPTURE cycle: no strobe and resp_data untouched.
    prev      = resp_data;
    core_lat  = 3;
    req_valid = 1'b1;
    req_word  = 1'b0;
    src1      = 64'd11;
    src2      = 64'd13;
    repeat (6) step();
    flush     = 1'b1;
    req_valid = 1'b0;
    exp_mv++;
    step();
    flush = 1'b0;
    check_eq("capflush_no_resp", 64'(resp_valid), 64'd0);
    check_eq("capflush_data_kept", resp_data, prev);
    repeat (3) step();
    check_eq("capflush_resp_cnt", 64'(n_rv), 64'(exp_rv));

    // Zero operand (fast path when enabled, through the core otherwise).
    run_op(1'b0, 64'd0, 64'h0000_0000_0001_E240, 3, 1'b0);
    run_op(1'b1, 64'hDEAD_BEEF_0000_0000, 64'd77, 2, 1'b0);

    // Randomized ops.
    for (int i = 0; i < 24; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      bit          rw;
      bit          rh;
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 4 == 1) ra = 64'($urandom_range(0, 9));
      if (i % 5 == 2) rb = -64'($urandom_range(1, 9));
      rw = 1'($urandom_range(0, 1));
      rh = (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_op(rw, ra, rb, int'($urandom_range(1, 8)), rh);
    end

    // Reset in the middle of WAIT.
    run_op(1'b0, 64'd6, 64'd7, 2, 1'b0);
    core_lat  = 40;
    req_valid = 1'b1;
    req_word  = 1'b0;
    src1      = 64'd21;
    src2      = 64'd2;
    repeat (5) step();
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    check_eq("midrst_resetn", 64'(mul_resetn), 64'd0);
    exp_mv++;
    step();
    check_eq("midrst_resp_valid", 64'(resp_valid), 64'd0);
    check_eq("midrst_resp_data", resp_data, 64'd0);
    check_eq("midrst_mul_a", mul_a, 64'd0);
    check_eq("midrst_mul_valid", 64'(mul_valid), 64'd0);
    reset = 1'b0;
    step();
    run_op(1'b0, 64'd3, 64'd5, 2, 1'b0);
    repeat (5) step();
    check_eq("final_resp_cnt", 64'(n_rv), 64'(exp_rv));
    check_eq("final_mv_cnt", 64'(n_mv), 64'(exp_mv));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
